div_result_display: RTL and testbench



---
 rtl/div_pkg.sv | 29 ++
 rtl/div_result_display_if.sv | 24 ++
 rtl/div_result_display_seg7_decode.sv | 18 +
 rtl/div_result_display.sv | 127 ++++++++++++
 tb/tb_div_result_display.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider result display.
// Segment encodings are {g,f,e,d,c,b,a}, active high.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        Q_TENS,
        Q_ONES,
        R_TENS,
        R_ONES,
        GAP
    } disp_state_t;

    localparam int Q_MSB = 7;
    localparam int Q_LSB = 4;
    localparam int R_MSB = 3;
    localparam int R_LSB = 0;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Entry n is the pattern for digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/div_result_display_if.sv
// Result handshake from the divider to the display.
// Data is {quotient[7:4], remainder[3:0]}; dz qualified by valid.
interface div_result_display_if;

    logic       res_valid;
    logic [7:0] res_data;
    logic       res_dz;
    logic       res_ready;

    modport master (
        output res_valid,
        output res_data,
        output res_dz,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_dz,
        output res_ready
    );

endinterface

// File: rtl/div_result_display_seg7_decode.sv
// Single-digit 7-segment decoder with blanking.
// Out-of-range digits render blank.
module seg7_decode
    import div_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup, blank wins
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9)
            seg = SEG_DIGITS[digit];
    end

endmodule

// File: rtl/div_result_display.sv
// Holds one divider result and cycles it onto a 7-segment
// display: q tens, q ones, r tens, r ones, gap, repeat.
module div_result_display
    import div_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    div_result_display_if.slave        res,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic                       busy
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] TC = CW'(DWELL_CYCLES - 1);

    disp_state_t   state;
    disp_state_t   state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    hold_q;
    logic [3:0]    hold_r;
    logic          hold_dz;
    logic          xfer;

    logic          q_slot;
    logic          tens_slot;
    logic          ones_slot;
    logic [3:0]    val;
    logic          tens;
    logic [3:0]    ones;
    logic [3:0]    dec_digit;
    logic          dec_blank;
    logic [6:0]    dec_seg;

    assign res.res_ready = !rst && (state == IDLE || state == GAP);
    assign xfer = res.res_valid && res.res_ready;

    // State, dwell counter and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hold_q  <= '0;
            hold_r  <= '0;
            hold_dz <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (xfer) begin
                hold_q  <= res.res_data[Q_MSB:Q_LSB];
                hold_r  <= res.res_data[R_MSB:R_LSB];
                hold_dz <= res.res_dz;
            end
        end
    end

    // Next state: transfer wins, else advance at terminal count
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (xfer) begin
            state_n = Q_TENS;
            cnt_n   = '0;
        end else if (state != IDLE) begin
            if (cnt == TC) begin
                cnt_n = '0;
                unique case (state)
                    Q_TENS:  state_n = Q_ONES;
                    Q_ONES:  state_n = R_TENS;
                    R_TENS:  state_n = R_ONES;
                    R_ONES:  state_n = GAP;
                    GAP:     state_n = Q_TENS;
                    default: state_n = IDLE;
                endcase
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign q_slot    = (state == Q_TENS) || (state == Q_ONES);
    assign tens_slot = (state == Q_TENS) || (state == R_TENS);
    assign ones_slot = (state == Q_ONES) || (state == R_ONES);
    assign val       = q_slot ? hold_q : hold_r;
    assign tens      = (val >= 4'd10);
    assign ones      = tens ? val - 4'd10 : val;

    // Slot-select mux into the shared decoder
    always_comb begin
        dec_digit = 4'd0;
        dec_blank = 1'b1;
        unique case (1'b1)
            tens_slot: begin
                dec_digit = {3'b000, tens};
                dec_blank = !tens;
            end
            ones_slot: begin
                dec_digit = ones;
                dec_blank = 1'b0;
            end
            default: begin
                dec_digit = 4'd0;
                dec_blank = 1'b1;
            end
        endcase
    end

    seg7_decode u_dec (
        .digit (dec_digit),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    // Divide-by-zero overrides the numeric digits
    always_comb begin
        seg = dec_seg;
        if (hold_dz && (tens_slot || ones_slot))
            seg = q_slot ? SEG_E : SEG_DASH;
    end

    assign dp   = (state == Q_ONES);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_result_display.sv
// Scoreboard bench for div_result_display, DWELL_CYCLES = 4.
// Stimulus queues per-cycle expectations; monitor compares.
module tb_div_result_display;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic       rdy;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_result_display_if rif ();

    div_result_display #(
        .DWELL_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .res  (rif),
        .seg  (seg),
        .dp   (dp),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input logic [6:0] s, input logic d,
                              input logic b, input logic r,
                              input string tag);
        exp_t e;
        e.seg  = s;
        e.dp   = d;
        e.busy = b;
        e.rdy  = r;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic run(input logic [6:0] s, input logic d,
                       input logic b, input logic r,
                       input int n, input logic v,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            rif.res_valid = v;
            expect_now(s, d, b, r, tag);
        end
    endtask

    // Offer a result during an IDLE/GAP cycle; accepted at next edge
    task automatic xfer(input logic [7:0] data, input logic dz,
                        input logic b, input string tag);
        tick();
        rif.res_valid = 1'b1;
        rif.res_data  = data;
        rif.res_dz    = dz;
        expect_now(7'h00, 1'b0, b, 1'b1, tag);
    endtask

    // Monitor: compare whatever was queued for this cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (seg !== e.seg || dp !== e.dp || busy !== e.busy ||
                rif.res_ready !== e.rdy) begin
                errors++;
                $display("FAIL %s t=%0t got seg=%h dp=%b busy=%b rdy=%b want seg=%h dp=%b busy=%b rdy=%b",
                         e.tag, $time, seg, dp, busy, rif.res_ready,
                         e.seg, e.dp, e.busy, e.rdy);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        rif.res_valid = 1'b0;
        rif.res_data  = 8'h00;
        rif.res_dz    = 1'b0;

        tick();
        expect_now(7'h00, 1'b0, 1'b0, 1'b0, "rst_hi");
        tick();
        rst = 1'b0;
        expect_now(7'h00, 1'b0, 1'b0, 1'b1, "rst_rel");
        run(7'h00, 1'b0, 1'b0, 1'b1, 9, 1'b0, "idle");

        // 10/3 -> q=3 r=1
        xfer(8'h31, 1'b0, 1'b0, "x31");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_qt");
        run(7'h4F, 1'b1, 1'b1, 1'b0, 4, 1'b0, "31_qo");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_rt");
        run(7'h06, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_ro");
        run(7'h00, 1'b0, 1'b1, 1'b1, 4, 1'b0, "31_gap");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_qt2");
        run(7'h4F, 1'b1, 1'b1, 1'b0, 4, 1'b0, "31_qo2");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_rt2");
        run(7'h06, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31_ro2");
        run(7'h00, 1'b0, 1'b1, 1'b1, 3, 1'b0, "31_gap2");

        // Transfer on the GAP terminal-count cycle: q=15 r=0
        xfer(8'hF0, 1'b0, 1'b1, "xF0_tc");
        run(7'h06, 1'b0, 1'b1, 1'b0, 4, 1'b0, "F0_qt");
        run(7'h6D, 1'b1, 1'b1, 1'b0, 4, 1'b0, "F0_qo");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "F0_rt");
        run(7'h3F, 1'b0, 1'b1, 1'b0, 4, 1'b0, "F0_ro");
        run(7'h00, 1'b0, 1'b1, 1'b1, 1, 1'b0, "F0_gap");

        // Divide-by-zero, accepted mid-GAP
        xfer(8'h00, 1'b1, 1'b1, "xdz_mid");
        run(7'h79, 1'b0, 1'b1, 1'b0, 4, 1'b0, "dz_qt");
        run(7'h79, 1'b1, 1'b1, 1'b0, 4, 1'b0, "dz_qo");
        run(7'h40, 1'b0, 1'b1, 1'b0, 4, 1'b0, "dz_rt");
        run(7'h40, 1'b0, 1'b1, 1'b0, 4, 1'b0, "dz_ro");
        run(7'h00, 1'b0, 1'b1, 1'b1, 3, 1'b0, "dz_gap");

        // 8'h31 again, then hold 8'h42 from mid-Q_ONES
        xfer(8'h31, 1'b0, 1'b1, "x31b");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "31b_qt");
        run(7'h4F, 1'b1, 1'b1, 1'b0, 2, 1'b0, "31b_qo");
        rif.res_data = 8'h42;
        rif.res_dz   = 1'b0;
        run(7'h4F, 1'b1, 1'b1, 1'b0, 2, 1'b1, "hold_qo");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b1, "hold_rt");
        run(7'h06, 1'b0, 1'b1, 1'b0, 4, 1'b1, "hold_ro");
        run(7'h00, 1'b0, 1'b1, 1'b1, 1, 1'b1, "hold_gap");
        run(7'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, "42_qt");
        run(7'h66, 1'b1, 1'b1, 1'b0, 4, 1'b0, "42_qo");
        run(7'h00, 1'b0, 1'b1, 1'b0, 2, 1'b0, "42_rt");

        // Reset mid R_TENS
        tick();
        rst = 1'b1;
        expect_now(7'h00, 1'b0, 1'b1, 1'b0, "rst_mid");
        tick();
        rst = 1'b0;
        expect_now(7'h00, 1'b0, 1'b0, 1'b1, "rst_idle");
        run(7'h00, 1'b0, 1'b0, 1'b1, 12, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
